// File: rtl/vga_scan_controller.sv
// vga_scan_controller: pixel-tick divider, h/v scan, registered VGA syncs/colour and frame-synchronous image select.
// Optional feature macro VGA_TEST_PATTERN_EN adds a test_mode input that replaces rgb_in with 8 vertical colour bars.
module vga_scan_controller #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        next_image,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    input  logic [11:0] rgb_in,
    output logic [9:0]  h_count,
    output logic [9:0]  v_count,
    output logic [3:0]  image_index,
    output logic        pix_tick,
    output logic        frame_start,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] H_SS    = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] V_SS    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] BAR_W   = 10'(H_ACTIVE / 8);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    h_q, h_d, v_q, v_d;
    logic [3:0]    idx_q, idx_d;
    logic          pend_q, pend_d, fs_q, fs_d, hs_q, hs_d, vs_q, vs_d;
    logic [11:0]   rgb_q, rgb_d, src;
    logic          tick, h_last, v_last, wrap, active;
    logic [2:0]    bar;

    assign tick   = (div_q == DIV_LAST);
    assign h_last = (h_q == H_LAST);
    assign v_last = (v_q == V_LAST);
    assign wrap   = tick && h_last && v_last;
    assign active = (h_q < H_ACT) && (v_q < V_ACT);
    assign bar    = 3'(h_q / BAR_W);
`ifdef VGA_TEST_PATTERN_EN
    assign src    = test_mode ? {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}} : rgb_in;
`else
    assign src    = rgb_in;
`endif

    // Next-state: divider, scan counters, image select and the one-pixel-late output stage
    always_comb begin
        div_d  = tick ? '0 : div_q + 1'b1;
        h_d    = tick ? (h_last ? '0 : h_q + 10'd1) : h_q;
        v_d    = (tick && h_last) ? (v_last ? '0 : v_q + 10'd1) : v_q;
        pend_d = wrap ? 1'b0 : (pend_q | next_image);
        idx_d  = (wrap && (pend_q || next_image)) ? idx_q + 4'd1 : idx_q;
        fs_d   = wrap;
        rgb_d  = tick ? (active ? src : 12'h000) : rgb_q;
        hs_d   = tick ? ((h_q >= H_SS && h_q <= H_SE) ? SYNC_POL : ~SYNC_POL) : hs_q;
        vs_d   = tick ? ((v_q >= V_SS && v_q <= V_SE) ? SYNC_POL : ~SYNC_POL) : vs_q;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            h_q    <= '0;
            v_q    <= '0;
            idx_q  <= '0;
            pend_q <= 1'b0;
            fs_q   <= 1'b0;
            rgb_q  <= '0;
            hs_q   <= ~SYNC_POL;
            vs_q   <= ~SYNC_POL;
        end else begin
            div_q  <= div_d;
            h_q    <= h_d;
            v_q    <= v_d;
            idx_q  <= idx_d;
            pend_q <= pend_d;
            fs_q   <= fs_d;
            rgb_q  <= rgb_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
        end
    end

    assign h_count     = h_q;
    assign v_count     = v_q;
    assign image_index = idx_q;
    assign pix_tick    = tick;
    assign frame_start = fs_q;
    assign vga_hsync   = hs_q;
    assign vga_vsync   = vs_q;
    assign {vga_r, vga_g, vga_b} = rgb_q;
endmodule
